// File: rtl/hires_pkg.sv
// rtl/hires_pkg.sv - shared constants, option bit indices and FSM states for the hires port A arbiter
package hires_pkg;

  localparam logic [7:0] HIRES_X_PORT    = 8'h80;
  localparam logic [7:0] HIRES_Y_PORT    = 8'h81;
  localparam logic [7:0] HIRES_DATA_PORT = 8'h82;
  localparam logic [7:0] HIRES_OPT_PORT  = 8'h83;
  localparam logic [7:0] HIRES_OPT_RESET = 8'hFC;

  localparam int          X_LAST    = 79;
  localparam logic [14:0] FILL_LAST = 15'd20479;

  // options register bit positions; a set *_HOLD bit suppresses that step
  localparam int OPT_ENABLE    = 0;
  localparam int OPT_X_DEC     = 2;
  localparam int OPT_Y_DEC     = 3;
  localparam int OPT_RD_X_HOLD = 4;
  localparam int OPT_RD_Y_HOLD = 5;
  localparam int OPT_WR_X_HOLD = 6;
  localparam int OPT_WR_Y_HOLD = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ZRD1,
    ST_ZRD2,
    ST_ZRD3,
    ST_ZWR,
    ST_HWR,
    ST_FILL
  } hires_state_t;

endpackage

// File: rtl/hires_port_arbiter_if.sv
// rtl/hires_port_arbiter_if.sv - Z80 I/O, host engine and RAM port A signal bundle
interface hires_port_arbiter_if;

  logic [7:0]  TRS_A;
  logic [7:0]  TRS_D;
  logic        TRS_OUT;
  logic        TRS_IN;
  logic        io_access;

  logic        host_fill_req;
  logic [7:0]  host_fill_val;
  logic        host_wr_req;
  logic [14:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic        host_busy;

  logic        ram_ce;
  logic        ram_we;
  logic        ram_oce;
  logic [14:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  logic [7:0]  hires_dout;
  logic        hires_dout_rdy;
  logic        hires_enable;

  modport slave (
    input  TRS_A, TRS_D, TRS_OUT, TRS_IN, io_access,
    input  host_fill_req, host_fill_val, host_wr_req, host_addr, host_wdata,
    input  ram_dout,
    output host_ack, host_busy,
    output ram_ce, ram_we, ram_oce, ram_addr, ram_din,
    output hires_dout, hires_dout_rdy, hires_enable
  );

  modport master (
    output TRS_A, TRS_D, TRS_OUT, TRS_IN, io_access,
    output host_fill_req, host_fill_val, host_wr_req, host_addr, host_wdata,
    output ram_dout,
    input  host_ack, host_busy,
    input  ram_ce, ram_we, ram_oce, ram_addr, ram_din,
    input  hires_dout, hires_dout_rdy, hires_enable
  );

endinterface

// File: rtl/hires_addr_step.sv
// rtl/hires_addr_step.sv - next X/Y after a Z80 access; X wraps at 7 bits, Y at 8 bits
module hires_addr_step
  import hires_pkg::*;
(
  input  logic [6:0] x,
  input  logic [7:0] y,
  input  logic [7:2] opt,
  input  logic       is_write,
  output logic [6:0] x_next,
  output logic [7:0] y_next
);

  logic x_hold;
  logic y_hold;

  always_comb begin
    x_hold = is_write ? opt[OPT_WR_X_HOLD] : opt[OPT_RD_X_HOLD];
    y_hold = is_write ? opt[OPT_WR_Y_HOLD] : opt[OPT_RD_Y_HOLD];
    x_next = x;
    y_next = y;
    if (!x_hold) x_next = opt[OPT_X_DEC] ? x - 7'd1 : x + 7'd1;
    if (!y_hold) y_next = opt[OPT_Y_DEC] ? y - 8'd1 : y + 8'd1;
  end

endmodule

// File: rtl/hires_port_arbiter.sv
// rtl/hires_port_arbiter.sv - port A owner: Z80 80h-83h decode, X/Y/options, host write and fill in idle slots
module hires_port_arbiter
  import hires_pkg::*;
(
  input  logic                clk,
  input  logic                srst,
  hires_port_arbiter_if.slave bus
);

  hires_state_t state, state_nxt;
  logic [6:0]  x_q, x_nxt;
  logic [7:0]  y_q, y_nxt;
  logic [7:2]  opt_q;
  logic        opt_en_q;
  logic        out_prev, in_prev;
  logic        rd_pend, wr_pend, hw_pend, fill_active;
  logic [7:0]  wr_data, hw_data, fill_val, dout_q;
  logic [14:0] hw_addr, fill_cnt;

  logic out_act, in_act, out_edge, in_edge;
  logic ld_x, ld_y, ld_opt, z_wr_req, z_rd_req, step_en;

  // one request per I/O cycle however long the strobe is held
  assign out_act  = bus.io_access & ~bus.TRS_OUT;
  assign in_act   = bus.io_access & ~bus.TRS_IN;
  assign out_edge = out_act & ~out_prev;
  assign in_edge  = in_act & ~in_prev;
  assign ld_x     = out_edge && (bus.TRS_A == HIRES_X_PORT);
  assign ld_y     = out_edge && (bus.TRS_A == HIRES_Y_PORT);
  assign ld_opt   = out_edge && (bus.TRS_A == HIRES_OPT_PORT);
  assign z_wr_req = out_edge && (bus.TRS_A == HIRES_DATA_PORT);
  assign z_rd_req = in_edge && (bus.TRS_A == HIRES_DATA_PORT);
  assign step_en  = (state == ST_ZRD1) || (state == ST_ZWR);

  hires_addr_step u_step (
    .x        (x_q),
    .y        (y_q),
    .opt      (opt_q),
    .is_write (state == ST_ZWR),
    .x_next   (x_nxt),
    .y_next   (y_nxt)
  );

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state       <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      opt_q       <= HIRES_OPT_RESET[7:2];
      opt_en_q    <= HIRES_OPT_RESET[OPT_ENABLE];
      out_prev    <= 1'b0;
      in_prev     <= 1'b0;
      rd_pend     <= 1'b0;
      wr_pend     <= 1'b0;
      hw_pend     <= 1'b0;
      fill_active <= 1'b0;
      wr_data     <= '0;
      hw_data     <= '0;
      hw_addr     <= '0;
      fill_val    <= '0;
      fill_cnt    <= '0;
      dout_q      <= '0;
    end else begin
      state    <= state_nxt;
      out_prev <= out_act;
      in_prev  <= in_act;

      // a register load on the same clk as a step takes priority
      if (ld_x)         x_q <= bus.TRS_D[6:0];
      else if (step_en) x_q <= x_nxt;
      if (ld_y)         y_q <= bus.TRS_D;
      else if (step_en) y_q <= y_nxt;
      if (ld_opt) begin
        opt_q    <= bus.TRS_D[7:2];
        opt_en_q <= bus.TRS_D[OPT_ENABLE];
      end

      if (state == ST_ZRD1) rd_pend <= 1'b0;
      if (z_rd_req)         rd_pend <= 1'b1;
      if (state == ST_ZWR)  wr_pend <= 1'b0;
      if (z_wr_req) begin
        wr_pend <= 1'b1;
        wr_data <= bus.TRS_D;
      end

      if (state == ST_HWR) begin
        hw_pend <= 1'b0;
      end else if (bus.host_wr_req && !hw_pend) begin
        hw_pend <= 1'b1;
        hw_addr <= bus.host_addr;
        hw_data <= bus.host_wdata;
      end

      if (bus.host_fill_req && !(fill_active || hw_pend)) begin
        fill_active <= 1'b1;
        fill_cnt    <= '0;
        fill_val    <= bus.host_fill_val;
      end else if (state == ST_FILL) begin
        if (fill_cnt == FILL_LAST) fill_active <= 1'b0;
        else                       fill_cnt    <= fill_cnt + 15'd1;
      end

      if (state == ST_ZRD3) dout_q <= bus.ram_dout;
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.ram_ce         = 1'b0;
    bus.ram_we         = 1'b0;
    bus.ram_oce        = 1'b0;
    bus.ram_addr       = {x_q, y_q};
    bus.ram_din        = wr_data;
    bus.host_ack       = 1'b0;
    bus.hires_dout_rdy = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_pend)          state_nxt = ST_ZRD1;
        else if (wr_pend)     state_nxt = ST_ZWR;
        else if (hw_pend)     state_nxt = ST_HWR;
        else if (fill_active) state_nxt = ST_FILL;
      end
      ST_ZRD1: begin
        bus.ram_ce = 1'b1;
        state_nxt  = ST_ZRD2;
      end
      ST_ZRD2: begin
        bus.ram_oce = 1'b1;
        state_nxt   = ST_ZRD3;
      end
      ST_ZRD3: begin
        bus.hires_dout_rdy = 1'b1;
        state_nxt          = ST_IDLE;
      end
      ST_ZWR: begin
        bus.ram_ce = 1'b1;
        bus.ram_we = 1'b1;
        state_nxt  = ST_IDLE;
      end
      ST_HWR: begin
        bus.ram_ce   = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_addr = hw_addr;
        bus.ram_din  = hw_data;
        bus.host_ack = 1'b1;
        state_nxt    = ST_IDLE;
      end
      ST_FILL: begin
        bus.ram_ce   = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_addr = fill_cnt;
        bus.ram_din  = fill_val;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // the output register is valid during ZRD3, so present it directly then hold it
  assign bus.hires_dout   = (state == ST_ZRD3) ? bus.ram_dout : dout_q;
  assign bus.host_busy    = fill_active | hw_pend;
  assign bus.hires_enable = opt_en_q;

endmodule

// File: tb/tb_hires_port_arbiter.sv
// tb/tb_hires_port_arbiter.sv - scoreboard bench for hires_port_arbiter with a registered-output RAM model
module tb_hires_port_arbiter;

  typedef struct {
    logic [7:0] data;
    int         ecyc;
    int         minl;
    int         maxl;
  } rd_exp_t;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  logic clk;
  logic srst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  hires_port_arbiter_if bus ();

  hires_port_arbiter dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      ack_q[$];
  bit      sb_wr_en = 1'b0;
  bit      fill_mon = 1'b0;
  bit      fill_done = 1'b0;
  int      fill_next = 0;
  int      fill_wr_cnt = 0;
  int      fill_seq_err = 0;
  int      fill_data_err = 0;
  int      fill_busy_low = 0;
  int      fill_last_cyc = -1;

  logic [7:0] mem [0:32767];
  logic [7:0] lat_q;

  function automatic logic [7:0] pat(input int a);
    logic [14:0] v;
    v = a[14:0];
    return v[7:0] ^ {1'b0, v[14:8]} ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (bus.ram_ce && bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    if (bus.ram_ce && !bus.ram_we) lat_q <= mem[bus.ram_addr];
    if (bus.ram_oce) bus.ram_dout <= lat_q;
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.hires_dout_rdy) begin
      if (rd_q.size() == 0) begin
        chk(1'b0, "unexpected_rdy", bus.hires_dout, 0);
      end else begin
        rd_exp_t e;
        int lat;
        e = rd_q.pop_front();
        lat = cyc - e.ecyc;
        chk(bus.hires_dout == e.data, "rd_data", bus.hires_dout, e.data);
        chk(lat >= e.minl && lat <= e.maxl, "rd_latency", lat, e.maxl);
      end
    end
    if (sb_wr_en && bus.ram_ce && bus.ram_we) begin
      if (wr_q.size() == 0) begin
        chk(1'b0, "unexpected_write", {bus.ram_addr, bus.ram_din}, 0);
      end else begin
        wr_exp_t w;
        w = wr_q.pop_front();
        chk(bus.ram_addr == w.addr && bus.ram_din == w.data, "ram_write",
            {bus.ram_addr, bus.ram_din}, {w.addr, w.data});
      end
    end
    if (bus.host_ack) begin
      if (ack_q.size() == 0) chk(1'b0, "unexpected_ack", cyc, 0);
      else begin
        int ea;
        ea = ack_q.pop_front();
        chk(cyc == ea, "host_ack_cycle", cyc, ea);
      end
    end
    if (fill_mon && !fill_done) begin
      if (!bus.host_busy) fill_busy_low++;
      if (bus.ram_ce && bus.ram_we) begin
        if (int'(bus.ram_addr) != fill_next) fill_seq_err++;
        if (bus.ram_din != 8'h55) fill_data_err++;
        fill_wr_cnt++;
        fill_next++;
        if (bus.ram_addr == hires_pkg::FILL_LAST) begin
          fill_last_cyc = cyc;
          fill_done = 1'b1;
        end
      end
    end
  end

  task automatic z80_io(input bit rd, input logic [7:0] port, input logic [7:0] d,
                        input logic [7:0] exp, input int minl, input int maxl);
    @(posedge clk); #1;
    if (rd) rd_q.push_back('{exp, cyc + 1, minl, maxl});
    bus.TRS_A = port;
    bus.TRS_D = d;
    bus.io_access = 1'b1;
    if (rd) bus.TRS_IN = 1'b0;
    else    bus.TRS_OUT = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.io_access = 1'b0;
    bus.TRS_IN = 1'b1;
    bus.TRS_OUT = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic start_fill(input logic [7:0] val);
    @(posedge clk); #1;
    bus.host_fill_req = 1'b1;
    bus.host_fill_val = val;
    @(posedge clk); #1;
    bus.host_fill_req = 1'b0;
  endtask

  initial begin
    int drop_cyc;
    int bad;
    for (int i = 0; i < 32768; i++) mem[i] = pat(i);
    srst = 1'b1;
    bus.TRS_A = 8'h00;
    bus.TRS_D = 8'h00;
    bus.TRS_OUT = 1'b1;
    bus.TRS_IN = 1'b1;
    bus.io_access = 1'b0;
    bus.host_fill_req = 1'b0;
    bus.host_fill_val = 8'h00;
    bus.host_wr_req = 1'b0;
    bus.host_addr = '0;
    bus.host_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk(bus.ram_ce == 1'b0, "rst_ram_ce", bus.ram_ce, 0);
    chk(bus.ram_we == 1'b0, "rst_ram_we", bus.ram_we, 0);
    chk(bus.ram_oce == 1'b0, "rst_ram_oce", bus.ram_oce, 0);
    chk(bus.hires_dout == 8'h00, "rst_hires_dout", bus.hires_dout, 0);
    chk(bus.hires_dout_rdy == 1'b0, "rst_rdy", bus.hires_dout_rdy, 0);
    chk(bus.host_ack == 1'b0, "rst_ack", bus.host_ack, 0);
    chk(bus.host_busy == 1'b0, "rst_busy", bus.host_busy, 0);
    chk(bus.hires_enable == 1'b0, "rst_enable", bus.hires_enable, 0);
    srst = 1'b0;

    // write at {05,10} with increment stepping, second write proves X=06, Y=11
    sb_wr_en = 1'b1;
    z80_io(1'b0, 8'h80, 8'h05, 8'h00, 0, 0);
    z80_io(1'b0, 8'h81, 8'h10, 8'h00, 0, 0);
    z80_io(1'b0, 8'h83, 8'h00, 8'h00, 0, 0);
    wr_q.push_back('{15'h0510, 8'hAA});
    z80_io(1'b0, 8'h82, 8'hAA, 8'h00, 0, 0);
    wr_q.push_back('{15'h0611, 8'hBB});
    z80_io(1'b0, 8'h82, 8'hBB, 8'h00, 0, 0);

    // decrement stepping wraps {00,00} to {7F,FF}
    z80_io(1'b0, 8'h83, 8'h0C, 8'h00, 0, 0);
    z80_io(1'b0, 8'h80, 8'h00, 8'h00, 0, 0);
    z80_io(1'b0, 8'h81, 8'h00, 8'h00, 0, 0);
    z80_io(1'b1, 8'h82, 8'h00, 8'h3C, 3, 3);
    z80_io(1'b1, 8'h82, 8'h00, 8'hBC, 3, 3);
    repeat (5) @(posedge clk);
    #1;
    chk(bus.hires_dout == 8'hBC, "dout_hold", bus.hires_dout, 8'hBC);
    sb_wr_en = 1'b0;

    // fill 55h with a Z80 read of {4F,EF} landing mid-fill
    start_fill(8'h55);
    fill_mon = 1'b1;
    repeat (4) @(posedge clk);
    z80_io(1'b0, 8'h80, 8'h4F, 8'h00, 0, 0);
    z80_io(1'b0, 8'h81, 8'hEF, 8'h00, 0, 0);
    z80_io(1'b1, 8'h82, 8'h00, 8'h9C, 3, 4);
    drop_cyc = -1;
    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (!bus.host_busy) begin
        drop_cyc = cyc;
        break;
      end
    end
    chk(drop_cyc >= 0, "fill_timeout", drop_cyc, 0);
    chk(drop_cyc == fill_last_cyc + 1, "busy_drop_cycle", drop_cyc, fill_last_cyc + 1);
    chk(fill_wr_cnt == 20480, "fill_write_count", fill_wr_cnt, 20480);
    chk(fill_seq_err == 0, "fill_addr_sequence", fill_seq_err, 0);
    chk(fill_data_err == 0, "fill_write_data", fill_data_err, 0);
    chk(fill_busy_low == 0, "fill_busy_gap", fill_busy_low, 0);
    bad = 0;
    for (int a = 0; a <= 20479; a++) if (mem[a] != 8'h55) bad++;
    chk(bad == 0, "fill_ram_contents", bad, 0);

    // Z80 write and host write on the same clk: Z80 first, ack in the HWR slot
    sb_wr_en = 1'b1;
    z80_io(1'b0, 8'h80, 8'h12, 8'h00, 0, 0);
    z80_io(1'b0, 8'h81, 8'h34, 8'h00, 0, 0);
    wr_q.push_back('{15'h1234, 8'h99});
    wr_q.push_back('{15'h2040, 8'h66});
    @(posedge clk); #1;
    ack_q.push_back(cyc + 4);
    bus.TRS_A = 8'h82;
    bus.TRS_D = 8'h99;
    bus.io_access = 1'b1;
    bus.TRS_OUT = 1'b0;
    bus.host_wr_req = 1'b1;
    bus.host_addr = {7'h20, 8'h40};
    bus.host_wdata = 8'h66;
    @(posedge clk); #1;
    bus.host_wr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.io_access = 1'b0;
    bus.TRS_OUT = 1'b1;
    repeat (6) @(posedge clk);
    chk(mem[15'h1234] == 8'h99, "z80_byte", mem[15'h1234], 8'h99);
    chk(mem[15'h2040] == 8'h66, "host_byte", mem[15'h2040], 8'h66);
    sb_wr_en = 1'b0;

    // reset mid-fill, then options back at FCh (no stepping) and enable via 83h
    start_fill(8'hE7);
    repeat (100) @(posedge clk);
    #1;
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(bus.host_busy == 1'b0, "reset_busy", bus.host_busy, 0);
    chk(bus.ram_ce == 1'b0, "reset_ram_ce", bus.ram_ce, 0);
    chk(bus.hires_dout == 8'h00, "reset_dout", bus.hires_dout, 0);
    srst = 1'b0;
    sb_wr_en = 1'b1;
    wr_q.push_back('{15'h0000, 8'h11});
    z80_io(1'b0, 8'h82, 8'h11, 8'h00, 0, 0);
    wr_q.push_back('{15'h0000, 8'h22});
    z80_io(1'b0, 8'h82, 8'h22, 8'h00, 0, 0);
    chk(bus.host_busy == 1'b0, "post_reset_busy", bus.host_busy, 0);
    chk(bus.hires_enable == 1'b0, "pre_enable", bus.hires_enable, 0);
    z80_io(1'b0, 8'h83, 8'h01, 8'h00, 0, 0);
    #1;
    chk(bus.hires_enable == 1'b1, "enable_set", bus.hires_enable, 1);

    repeat (10) @(posedge clk);
    chk(rd_q.size() == 0, "rd_left", rd_q.size(), 0);
    chk(wr_q.size() == 0, "wr_left", wr_q.size(), 0);
    chk(ack_q.size() == 0, "ack_left", ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
